arm_imm_encoder: RTL and testbench
==================================

# arm_imm_encoder

Iterative encoder that converts a 32-bit constant into the 12-bit ARM data-processing immediate field (rotate_imm[11:8], immed_8[7:0]). Its output, fed through the pipeline's Val2 immediate path, reproduces the constant. The block is the inverse of the Val2 immediate decode. It sits beside the instruction-memory image builder and the test harness, and produces `shift_operand` for synthesized instructions. It also reports when the bitwise complement is encodable instead, which enables MOV→MVN substitution.

## Interface
Parameters: none.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- value  input  32  constant to encode; latched when start is accepted
- busy  output  1  search in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- found  output  1  an encoding exists (direct or inverted)
- inverted  output  1  encoding is for ~value (valid when found=1)
- shift_operand  output  12  {rotate_imm, immed_8}; 12'h000 when found=0

## Operation
- Decode rule to invert: value = ROR({24'b0, immed_8}, 2*rotate_imm).
- Test for rotation r: direct hit when ROL(V, 2r)[31:8] == 0; then immed_8 = ROL(V, 2r)[7:0]. Inverted hit uses ~V in place of V.
- Each search cycle evaluates both tests combinationally for one r, using one rotator or two.
- FSM states:
  - IDLE → SEARCH on start with busy=0. Latch V=value, r=0, clear the inverted-candidate register.
  - SEARCH:
    - Direct hit at r: finish with found=1, inverted=0, shift_operand={r, imm}. Go to IDLE.
    - Otherwise, an inverted hit while no candidate is stored: store {r, imm}. The first (smallest) r wins.
    - r==15 without a direct hit: finish with the stored candidate (found=1, inverted=1) if one exists. Else found=0, inverted=0, shift_operand=0.
    - Otherwise r←r+1.
- Priority: a direct hit at any r beats an inverted hit at any r. Among hits of the same kind, the smallest r wins.
- V=0 gives a direct hit at r=0 with shift_operand=12'h000.
- start while busy=1 is ignored; V is not re-latched.
- found, inverted and shift_operand are registered. They change only at the edge that raises done, and hold until the next done.

## Timing
- Reset values: busy=0, done=0, found=0, inverted=0, shift_operand=0, FSM=IDLE, r=0.
- Reset asserted mid-search aborts the search at that edge. No done pulse is generated; all outputs return to their reset values.
- start accepted at edge T: busy=1 from T+1. Rotation r is tested in the cycle after edge T+1+r.
- Direct hit at r: at edge T+2+r, done=1, busy=0 and results update. Latency is r+2 edges after acceptance, with 2 minimum.
- No direct hit: done at edge T+17, regardless of any inverted hit.
- done is high for exactly one cycle. In that cycle busy=0, so start is accepted back-to-back at the next edge.
- No output depends combinationally on start or value.

## Test plan
- value=32'h000000FF, start at T → busy at T+1; done at T+2 with found=1, inverted=0, shift_operand=12'h0FF.
- value=32'hF000000F → done at T+4 with shift_operand=12'h2FF, inverted=0.
- value=32'hFFFFFF00 → no direct hit; done at T+17 with found=1, inverted=1, shift_operand=12'h0FF.
- value=32'h00000101 → done at T+17 with found=0, inverted=0, shift_operand=12'h000.
- Sequence checks:
  - Issue start with value=32'hFF000000. Pulse start with value=32'h1 at T+2 while busy; that pulse is ignored.
  - The search completes at T+6 with shift_operand=12'h4FF.
  - Start a new search with value=32'h00000101 and assert rst at T+5. All outputs are 0 at T+6, and no done pulse appears afterwards.
- Back-to-back: start asserted in the done cycle is accepted. Check value=0 → done two cycles later with shift_operand=12'h000 and found=1.

Source files
------------

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder
// ---------------------------------------------------------------------------
// Iterative encoder that turns a 32-bit constant into the 12-bit ARM
// data-processing immediate {rotate_imm[3:0], immed_8[7:0]}, i.e. the inverse
// of value = ROR({24'b0, immed_8}, 2*rotate_imm). One rotation is tried per
// cycle. A direct encoding at any rotation beats an encoding of ~value, which
// is reported through `inverted` so the caller can substitute MVN for MOV.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         request, only honoured while idle
//   value         constant to encode, captured when start is accepted
//   busy          search in progress
//   done          one-cycle pulse, results valid from this cycle
//   found         an encoding (direct or inverted) exists
//   inverted      the encoding is for ~value
//   shift_operand {rotate_imm, immed_8}; 12'h000 when nothing was found
// ---------------------------------------------------------------------------
module arm_imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        inverted,
    output logic [11:0] shift_operand
);

    // IDLE -> LOAD (accept cycle, busy still low) -> SEARCH (one rotation per cycle)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SEARCH = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] value_r;
    logic [3:0]  rot_r;
    logic        cand_valid_r;
    logic [11:0] cand_r;

    logic        busy_r;
    logic        done_r;
    logic        found_r;
    logic        inverted_r;
    logic [11:0] shift_operand_r;

    logic [4:0]  rot_amt_s;
    logic [31:0] direct_rot_s;
    logic [31:0] inv_rot_s;
    logic        direct_hit_s;
    logic        inv_hit_s;
    logic        finish_s;
    logic        cand_store_s;
    logic        found_nxt_s;
    logic        inverted_nxt_s;
    logic [11:0] shift_operand_nxt_s;

    // Rotate-left of a 32-bit word; the upper half of the doubled word
    // shifted left is exactly the rotated value, including amt = 0.
    function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {v, v} << amt;
        return dbl[63:32];
    endfunction

    // Undoing ROR by 2r is ROL by 2r: a hit means only the low byte survives.
    assign rot_amt_s    = {rot_r, 1'b0};
    assign direct_rot_s = rol32(value_r, rot_amt_s);
    assign inv_rot_s    = rol32(~value_r, rot_amt_s);
    assign direct_hit_s = (direct_rot_s[31:8] == 24'd0);
    assign inv_hit_s    = (inv_rot_s[31:8] == 24'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (direct_hit_s || (rot_r == 4'd15)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decision: result to publish when the search finishes, and
    // whether the current rotation becomes the stored inverted candidate.
    always_comb begin
        finish_s            = 1'b0;
        cand_store_s        = 1'b0;
        found_nxt_s         = 1'b0;
        inverted_nxt_s      = 1'b0;
        shift_operand_nxt_s = 12'h000;
        if (state_r == ST_SEARCH) begin
            finish_s     = direct_hit_s || (rot_r == 4'd15);
            cand_store_s = !direct_hit_s && inv_hit_s && !cand_valid_r;
            if (direct_hit_s) begin
                found_nxt_s         = 1'b1;
                inverted_nxt_s      = 1'b0;
                shift_operand_nxt_s = {rot_r, direct_rot_s[7:0]};
            end else if (cand_valid_r) begin
                found_nxt_s         = 1'b1;
                inverted_nxt_s      = 1'b1;
                shift_operand_nxt_s = cand_r;
            end else if (inv_hit_s) begin
                // First inverted hit can land on r = 15 itself.
                found_nxt_s         = 1'b1;
                inverted_nxt_s      = 1'b1;
                shift_operand_nxt_s = {rot_r, inv_rot_s[7:0]};
            end else begin
                found_nxt_s         = 1'b0;
                inverted_nxt_s      = 1'b0;
                shift_operand_nxt_s = 12'h000;
            end
        end else begin
            finish_s     = 1'b0;
            cand_store_s = 1'b0;
        end
    end

    // Search datapath: operand capture, rotation counter, inverted candidate
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r      <= 32'd0;
            rot_r        <= 4'd0;
            cand_valid_r <= 1'b0;
            cand_r       <= 12'h000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        value_r      <= value;
                        rot_r        <= 4'd0;
                        cand_valid_r <= 1'b0;
                        cand_r       <= 12'h000;
                    end else begin
                        rot_r        <= 4'd0;
                    end
                end
                ST_LOAD: begin
                    rot_r <= 4'd0;
                end
                ST_SEARCH: begin
                    if (cand_store_s) begin
                        cand_valid_r <= 1'b1;
                        cand_r       <= {rot_r, inv_rot_s[7:0]};
                    end else begin
                        cand_valid_r <= cand_valid_r;
                    end
                    if (finish_s) begin
                        rot_r <= 4'd0;
                    end else begin
                        rot_r <= rot_r + 4'd1;
                    end
                end
                default: begin
                    rot_r <= 4'd0;
                end
            endcase
        end
    end

    // Registered outputs; results only move on the edge that raises done
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            found_r         <= 1'b0;
            inverted_r      <= 1'b0;
            shift_operand_r <= 12'h000;
        end else begin
            busy_r <= (state_nxt_s == ST_SEARCH);
            done_r <= finish_s;
            if (finish_s) begin
                found_r         <= found_nxt_s;
                inverted_r      <= inverted_nxt_s;
                shift_operand_r <= shift_operand_nxt_s;
            end else begin
                found_r         <= found_r;
                inverted_r      <= inverted_r;
                shift_operand_r <= shift_operand_r;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign found         = found_r;
    assign inverted      = inverted_r;
    assign shift_operand = shift_operand_r;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Testbench for arm_imm_encoder: scoreboard of expected results, popped and
// compared by a monitor whenever done pulses.
module tb_arm_imm_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        found;
    logic        inverted;
    logic [11:0] shift_operand;

    typedef struct {
        logic        found;
        logic        inv;
        logic [11:0] so;
        int          done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   n_tests;
    int   n_fail;

    arm_imm_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .inverted      (inverted),
        .shift_operand (shift_operand)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    // Reference: brute-force search over every 12-bit immediate, rotation first.
    task automatic model(input logic [31:0] v, output logic f, output logic iv,
                         output logic [11:0] so, output int lat);
        f = 1'b0; iv = 1'b0; so = 12'h000; lat = 17;
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 256; i++)
                if (!f && ror32(i, 2 * r) == v) begin
                    f = 1'b1; so = {r[3:0], i[7:0]}; lat = r + 2;
                end
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < 256; i++)
                if (!f && ror32(i, 2 * r) == ~v) begin
                    f = 1'b1; iv = 1'b1; so = {r[3:0], i[7:0]};
                end
    endtask

    // Monitor: every done pulse is matched against the scoreboard head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("found", found, e.found);
                check_eq("inverted", inverted, e.inv);
                check_eq("shift_operand", shift_operand, e.so);
                check_eq("done_edge", cyc, e.done_cyc);
                check_eq("busy_in_done", busy, 1'b0);
            end
        end
    end

    // Called #1 after an edge; start is sampled on the following edge (T).
    // Returns #1 after T with the expectation queued.
    task automatic start_enc(input logic [31:0] v, input logic f, input logic iv,
                             input logic [11:0] so, input int lat);
        exp_t e;
        start = 1'b1;
        value = v;
        @(posedge clk); #1;
        start = 1'b0;
        value = $urandom;
        e.found = f; e.inv = iv; e.so = so; e.done_cyc = cyc + lat;
        sb_q.push_back(e);
    endtask

    task automatic start_model(input logic [31:0] v);
        logic f, iv;
        logic [11:0] so;
        int lat;
        model(v, f, iv, so, lat);
        start_enc(v, f, iv, so, lat);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb_q.size() != 0) begin
            check_eq("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        logic [31:0] v;
        cyc = 0; n_tests = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; value = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_found", found, 1'b0);
        check_eq("rst_inverted", inverted, 1'b0);
        check_eq("rst_so", shift_operand, 12'h000);
        rst = 1'b0;
        @(posedge clk); #1;

        // Direct hit at r=0: busy from T+1, done at T+2
        start_enc(32'h000000FF, 1'b1, 1'b0, 12'h0FF, 2);
        @(posedge clk); #1;
        check_eq("busy_t1", busy, 1'b1);
        drain();

        start_enc(32'hF000000F, 1'b1, 1'b0, 12'h2FF, 4);
        drain();
        start_enc(32'hFFFFFF00, 1'b1, 1'b1, 12'h0FF, 17);
        drain();
        start_enc(32'h00000101, 1'b0, 1'b0, 12'h000, 17);
        drain();

        // start while busy is ignored
        start_enc(32'hFF000000, 1'b1, 1'b0, 12'h4FF, 6);
        @(posedge clk); #1;
        start = 1'b1; value = 32'h00000001;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (4) @(posedge clk);
        #1;
        check_eq("hold_found", found, 1'b1);
        check_eq("hold_so", shift_operand, 12'h4FF);
        check_eq("hold_busy", busy, 1'b0);

        // Reset mid-search
        start_enc(32'h00000101, 1'b0, 1'b0, 12'h000, 17);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_found", found, 1'b0);
        check_eq("abort_inverted", inverted, 1'b0);
        check_eq("abort_so", shift_operand, 12'h000);
        repeat (25) @(posedge clk);
        #1;

        // Back-to-back: start in the done cycle
        start_enc(32'h000000FF, 1'b1, 1'b0, 12'h0FF, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("b2b_done", done, 1'b1);
        start_enc(32'h00000000, 1'b1, 1'b0, 12'h000, 2);
        drain();

        // Mixed encodable / complement-encodable / arbitrary values
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0:       v = ror32({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
                1:       v = ~ror32({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
                default: v = $urandom;
            endcase
            start_model(v);
            drain();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
